// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: run/halt/single-step debug controller with debounced step button and registered debug readout (define DEBUG_INT_HOLD_EN to hold interrupts raised while not running)
module mips_debug_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        debug_en,
  input  logic        debug_step,
  input  logic [6:0]  debug_addr,
  output logic [31:0] debug_data,
  output logic        cpu_en,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] pc_if,
  input  logic [31:0] pc_id,
  input  logic [31:0] pc_ex,
  input  logic [31:0] pc_mem,
  input  logic [31:0] pc_wb,
  input  logic [31:0] inst_id,
  input  logic        interrupter,
  output logic        int_out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2, STEP = 2'd3} state_t;
  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_db_cnt;
  logic                   r_stable, r_stable_q, r_cpu_en;
  logic                   w_s, w_step_pulse, w_cpu_en;
  logic [31:0]            r_step_cnt, r_cycle_cnt, r_debug_data, w_rd;
  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_step_pulse = r_stable & ~r_stable_q;
  assign rf_addr      = debug_addr[4:0];
  assign cpu_en       = r_cpu_en;
  assign debug_data   = r_debug_data;
  // bring the asynchronous step button into the clock domain
  always_ff @(posedge clk) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], debug_step};
  end
  // accept a level change only after it has held for DEBOUNCE_CYCLES
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_db_cnt   <= '0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
    end else begin
      r_stable_q <= r_stable;
      if (w_s == r_stable) r_db_cnt <= '0;
      else if (r_db_cnt == CW'(DEBOUNCE_CYCLES)) begin
        r_stable <= w_s;
        r_db_cnt <= '0;
      end else r_db_cnt <= r_db_cnt + CW'(1);
    end
  end
  // next state: only HALT honours a step press, everything else follows debug_en
  always_comb begin
    w_next   = (r_state == HALT && debug_en) ? (w_step_pulse ? STEP : HALT) : (debug_en ? HALT : RUN);
    w_cpu_en = (w_next == RUN) || (w_next == STEP);
  end
  // state, pipeline enable and run/step counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cpu_en    <= 1'b0;
      r_step_cnt  <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_cpu_en <= w_cpu_en;
      if (w_next == STEP) r_step_cnt <= r_step_cnt + 32'd1;
      if (r_cpu_en) r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end
  // debug read address decode
  always_comb begin
    w_rd = '0;
    case (debug_addr)
      7'h20:   w_rd = pc_if;
      7'h21:   w_rd = pc_id;
      7'h22:   w_rd = pc_ex;
      7'h23:   w_rd = pc_mem;
      7'h24:   w_rd = pc_wb;
      7'h25:   w_rd = inst_id;
      7'h26:   w_rd = r_step_cnt;
      7'h27:   w_rd = r_cycle_cnt;
      7'h28:   w_rd = {29'b0, r_state, r_cpu_en};
      default: w_rd = (debug_addr < 7'h20) ? rf_data : '0;
    endcase
  end
  // register the readout every cycle regardless of mode
  always_ff @(posedge clk) begin
    if (!rst) r_debug_data <= '0;
    else      r_debug_data <= w_rd;
  end
`ifdef DEBUG_INT_HOLD_EN
  logic r_int_hold;
  // remember an interrupt seen while not running and deliver it on the first RUN cycle
  always_ff @(posedge clk) begin
    if (!rst) r_int_hold <= 1'b0;
    else      r_int_hold <= (r_state == RUN) ? 1'b0 : (r_int_hold | interrupter);
  end
  assign int_out = (r_state == RUN) & (interrupter | r_int_hold);
`else
  assign int_out = interrupter;
`endif
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: directed self-checking bench for mips_debug_ctrl
module tb_mips_debug_ctrl;
  logic        clk, rst, debug_en, debug_step, interrupter;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data, rf_data, pc_if, pc_id, pc_ex, pc_mem, pc_wb, inst_id;
  logic        cpu_en, int_out;
  logic [4:0]  rf_addr;
  int          n_checks = 0;
  int          n_fail = 0;
  int          first, n, found;
  logic [6:0]  ra[8] = '{7'h05, 7'h20, 7'h22, 7'h24, 7'h25, 7'h29, 7'h50, 7'h7F};
  logic [31:0] re[8] = '{32'hDEADBEEF, 32'h00400000, 32'h00400010, 32'h00400008,
                         32'h8C080004, 32'h0, 32'h0, 32'h0};

  mips_debug_ctrl dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .debug_addr(debug_addr), .debug_data(debug_data), .cpu_en(cpu_en),
    .rf_addr(rf_addr), .rf_data(rf_data), .pc_if(pc_if), .pc_id(pc_id),
    .pc_ex(pc_ex), .pc_mem(pc_mem), .pc_wb(pc_wb), .inst_id(inst_id),
    .interrupter(interrupter), .int_out(int_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input int hi, output int f, output int cnt);
    f = 0;
    cnt = 0;
    debug_step = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == hi) debug_step = 1'b0;
      if (cpu_en) begin
        cnt++;
        if (f == 0) f = i;
      end
    end
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] exp, input string tag);
    debug_addr = a;
    tick();
    chk(tag, debug_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; debug_en = 1'b0; debug_step = 1'b0; interrupter = 1'b0;
    debug_addr = 7'h28; rf_data = 32'h0;
    pc_if = 32'h00400000; pc_id = 32'h00400004; pc_ex = 32'h00400010;
    pc_mem = 32'h0040000C; pc_wb = 32'h00400008; inst_id = 32'h8C080004;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_data", debug_data, 0);
    chk("rst_int", int_out, 0);
    rst = 1'b1;
    tick();
    chk("run_cpu_en", cpu_en, 1);
    chk("idle_read", debug_data, 0);
    tick();
    chk("run_state", debug_data, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_hold", cpu_en, 1);
    end
    debug_en = 1'b1;
    tick();
    chk("halt_cpu_en", cpu_en, 0);
    tick();
    chk("halt_state", debug_data, 4);
    press(10, first, n);
    chk("step1_edge", first, 8);
    chk("step1_width", n, 1);
    rd(7'h26, 1, "step_cnt1");
    press(10, first, n);
    chk("step2_width", n, 1);
    rd(7'h26, 2, "step_cnt2");
    press(3, first, n);
    chk("glitch_none", n, 0);
    rd(7'h26, 2, "glitch_cnt");
    rf_data = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      debug_addr = ra[i];
      #1;
      chk("rf_addr", rf_addr, 32'(ra[i][4:0]));
      tick();
      chk("readout", debug_data, re[i]);
    end
    interrupter = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
`ifdef DEBUG_INT_HOLD_EN
      chk("int_halted", int_out, 0);
`else
      chk("int_halted", int_out, 1);
`endif
    end
    interrupter = 1'b0;
    #1;
    chk("int_low", int_out, 0);
    debug_en = 1'b0;
    tick();
    chk("resume_cpu_en", cpu_en, 1);
`ifdef DEBUG_INT_HOLD_EN
    chk("int_first_run", int_out, 1);
`else
    chk("int_first_run", int_out, 0);
`endif
    tick();
    chk("int_after", int_out, 0);
    debug_addr = 7'h27;
    force dut.r_cycle_cnt = 32'hFFFFFFFE;
    #1;
    release dut.r_cycle_cnt;
    tick();
    chk("wrap_fe", debug_data, 32'hFFFFFFFE);
    tick();
    chk("wrap_ff", debug_data, 32'hFFFFFFFF);
    tick();
    chk("wrap_0", debug_data, 32'h0);
    tick();
    chk("wrap_1", debug_data, 32'h1);
    debug_en = 1'b1;
    tick();
    found = 0;
    debug_step = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (cpu_en) found = 1;
    end
    chk("midstep_seen", found, 1);
    rst = 1'b0;
    debug_step = 1'b0;
    tick();
    chk("midstep_cpu_en", cpu_en, 0);
    chk("midstep_data", debug_data, 0);
    rst = 1'b1;
    debug_addr = 7'h26;
    tick();
    chk("midstep_cnt", debug_data, 0);
    chk("midstep_idle_en", cpu_en, 0);
    debug_addr = 7'h28;
    tick();
    tick();
    chk("midstep_halt", debug_data, 4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
CPU-side responder for the debug port driven by the board/bench: debug_en, debug_step, debug_addr, debug_data.
- Gates the pipeline with a run/halt/single-step FSM.
- Debounces the step button.
- Returns a registered debug read of register file, pipeline PCs and counters.
- Sits inside mips between the top-level debug pins and the datapath; also forwards the external interrupter line to the CPU.

Parameters:
SYNC_STAGES, 2, flops in the debug_step synchronizer (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debug_step level change is accepted (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (0 = reset)
debug_en  input  1  1 = debug mode (CPU halted except single steps)
debug_step  input  1  asynchronous step button, active-high
debug_addr  input  7  debug read address
debug_data  output  32  registered read data
cpu_en  output  1  pipeline clock-enable to all CPU stage registers
rf_addr  output  5  register-file debug read port address (= debug_addr[4:0], combinational)
rf_data  input  32  register-file debug read data (combinational from rf_addr)
pc_if, pc_id, pc_ex, pc_mem, pc_wb  input  32 each  stage PCs
inst_id  input  32  instruction in ID
interrupter  input  1  external interrupt request
int_out  output  1  interrupt request to CPU/CP0

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - state=IDLE, cpu_en=0, debug_data=0, int_out=0.
  - step_cnt=0, cycle_cnt=0, debounce counter=0, stable level=0, sync flops=0.
- Reset is honoured in any state, including mid-step.
- Step conditioning:
  - debug_step passes through SYNC_STAGES flops to give s.
  - The counter increments while s != stable and clears when s == stable.
  - When the counter reaches DEBOUNCE_CYCLES, stable <= s and the counter clears.
  - step_pulse is a 1-cycle pulse on a 0->1 change of stable.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM is registered; cpu_en is registered and decoded from next state.
  - IDLE: one cycle after reset; cpu_en=0; -> HALT if debug_en else RUN.
  - RUN: cpu_en=1; debug_en=1 -> HALT (cpu_en=0 from next cycle); step_pulse is discarded.
  - HALT: cpu_en=0; debug_en=0 -> RUN; else step_pulse=1 -> STEP.
  - STEP: cpu_en=1 for exactly one cycle; step_cnt+1; -> HALT if debug_en else RUN.
  - A step_pulse arriving while in STEP is discarded: at most one step per button press.
- Step latency:
  - debug_step rising edge (setup met) to cpu_en high = SYNC_STAGES + DEBOUNCE_CYCLES + 2 clk edges.
  - Default: 8.
- Counters:
  - cycle_cnt (32b) increments every cycle cpu_en=1.
  - step_cnt (32b) increments on entry to STEP.
  - Both wrap 0xFFFFFFFF -> 0 silently.
- Debug read:
  - debug_data <= mux(debug_addr) every clock, regardless of debug_en or state; latency 1 cycle.
  - Address map:
    - 0x00-0x1F: rf_data (rf_addr = debug_addr[4:0]); address 0 reads whatever rf_data returns.
    - 0x20-0x24: pc_if, pc_id, pc_ex, pc_mem, pc_wb.
    - 0x25: inst_id.
    - 0x26: step_cnt.
    - 0x27: cycle_cnt.
    - 0x28: {29'b0, state[1:0], cpu_en}, with state encoding IDLE=0, RUN=1, HALT=2, STEP=3.
    - 0x29-0x7F: 0.
  - A counter read in the same cycle the counter updates returns the pre-update value.
- Interrupt (macro off): int_out = interrupter, combinational pass-through.

Optional Feature:
Macro DEBUG_INT_HOLD_EN.
- Defined:
  - int_out = interrupter & (state==RUN).
  - An interrupter high seen in IDLE/HALT/STEP sets int_hold.
  - int_hold forces int_out=1 on the first RUN cycle, then clears.
  - If interrupter is still high in that cycle, it is not double-counted.
  - Reset clears int_hold.
- Undefined:
  - Combinational pass-through as above; no int_hold register.
  - Interrupts reaching the CPU while halted are the CPU's concern.

Test Plan:
- Reset hold: rst=0 for 5 cycles with debug_en=0 -> cpu_en=0, debug_data=0. After rst=1: IDLE 1 cycle, then cpu_en=1 continuously; addr 0x28 reads 0x3 (RUN, cpu_en=1).
- Halt/step: debug_en=1, then a 200 ns debug_step pulse at 20 ns clk.
  - cpu_en=0 except exactly one high cycle, 8 edges after the press.
  - Addr 0x26 then reads 1.
  - A second press gives step_cnt=2.
- Glitch rejection: in HALT, debug_step high for 3 cycles (below SYNC+DEBOUNCE threshold) -> no cpu_en pulse; step_cnt unchanged.
- Readout: in HALT, force rf_data=0xDEADBEEF and pc_ex=0x00400010, then sweep addr 0x05, 0x22, 0x50:
  - debug_data one cycle later = 0xDEADBEEF, 0x00400010, 0x0.
  - rf_addr=0x05 during the first read.
- Mid-step reset: assert rst=0 in the STEP cycle -> next cycle cpu_en=0, step_cnt=0, state IDLE.
- Interrupt: debug_en=1, interrupter high 100 ns while halted, then debug_en=0.
  - Macro off: int_out mirrors interrupter.
  - DEBUG_INT_HOLD_EN: int_out=0 while halted, then exactly one int_out=1 cycle on the first RUN cycle.
- Counter wrap: preload cycle_cnt to 0xFFFFFFFE via a force, run 3 cycles -> reads 0x00000001.
